// File: rtl/approx_mul_pipe.sv
// Three-stage unsigned multiplier built from four half-width sub-products.
// Approximate mode clears the low TRUNC bits of the low-by-low partial product.
module approx_mul_pipe #(
   parameter int WIDTH = 8,
   parameter int TRUNC = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] prod,
   output logic               out_mode,
   output logic               busy
);

   localparam int H  = WIDTH / 2;
   localparam int PW = 2 * WIDTH;
   localparam logic [WIDTH-1:0] LL_MASK = {WIDTH{1'b1}} << TRUNC;

   logic             adv;
   logic [2:0]       valid_reg;
   logic [2:0]       valid_next;

   logic [WIDTH-1:0] s1_a_reg;
   logic [WIDTH-1:0] s1_b_reg;
   logic             s1_mode_reg;

   logic [H-1:0]     half_a [2];
   logic [H-1:0]     half_b [2];
   logic [WIDTH-1:0] sub    [4];
   logic [WIDTH-1:0] ll_next;

   logic [WIDTH-1:0] s2_hh_reg;
   logic [WIDTH-1:0] s2_hl_reg;
   logic [WIDTH-1:0] s2_lh_reg;
   logic [WIDTH-1:0] s2_ll_reg;
   logic             s2_mode_reg;

   logic [WIDTH:0]   mid_sum;
   logic [PW-1:0]    prod_next;

   // A single advance enable keeps every stage in lockstep; a stalled output freezes all.
   assign adv        = !valid_reg[2] || out_ready;
   assign in_ready   = adv;
   assign out_valid  = valid_reg[2];
   assign busy       = |valid_reg;
   assign valid_next = {valid_reg[1:0], in_valid};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= '0;
      end else if (adv) begin
         valid_reg <= valid_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_a_reg    <= '0;
         s1_b_reg    <= '0;
         s1_mode_reg <= 1'b0;
      end else if (adv) begin
         s1_a_reg    <= a;
         s1_b_reg    <= b;
         s1_mode_reg <= mode;
      end
   end

   assign half_a[0] = s1_a_reg[H-1:0];
   assign half_a[1] = s1_a_reg[WIDTH-1:H];
   assign half_b[0] = s1_b_reg[H-1:0];
   assign half_b[1] = s1_b_reg[WIDTH-1:H];

   // sub[0]=ll, sub[1]=lh, sub[2]=hl, sub[3]=hh (index bit1 picks a half, bit0 picks b half)
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sub
         assign sub[gi] = WIDTH'(half_a[gi / 2]) * WIDTH'(half_b[gi % 2]);
      end
   endgenerate

   assign ll_next = s1_mode_reg ? (sub[0] & LL_MASK) : sub[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_hh_reg   <= '0;
         s2_hl_reg   <= '0;
         s2_lh_reg   <= '0;
         s2_ll_reg   <= '0;
         s2_mode_reg <= 1'b0;
      end else if (adv) begin
         s2_hh_reg   <= sub[3];
         s2_hl_reg   <= sub[2];
         s2_lh_reg   <= sub[1];
         s2_ll_reg   <= ll_next;
         s2_mode_reg <= s1_mode_reg;
      end
   end

   // Cross terms are summed one bit wider so their carry reaches the final adder.
   assign mid_sum   = {1'b0, s2_hl_reg} + {1'b0, s2_lh_reg};
   assign prod_next = (PW'(s2_hh_reg) << WIDTH) + (PW'(mid_sum) << H) + PW'(s2_ll_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod     <= '0;
         out_mode <= 1'b0;
      end else if (adv) begin
         prod     <= prod_next;
         out_mode <= s2_mode_reg;
      end
   end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Directed and random checks of approx_mul_pipe with a per-instance scoreboard,
// one 8-bit truncating instance and one 16-bit exact-equivalent instance.
module tb_approx_mul_pipe;

   typedef struct packed {
      logic [31:0] p;
      logic        m;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8, out_mode8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] prod8;

   logic        in_valid16, in_ready16, mode16, out_valid16, out_ready16, out_mode16, busy16;
   logic [15:0] a16, b16;
   logic [31:0] prod16;

   int checks   = 0;
   int failures = 0;
   exp_t q8[$];
   exp_t q16[$];

   always #5 clk = ~clk;

   approx_mul_pipe #(.WIDTH(8), .TRUNC(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8),
      .prod(prod8), .out_mode(out_mode8), .busy(busy8)
   );

   approx_mul_pipe #(.WIDTH(16), .TRUNC(0)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .mode(mode16), .out_valid(out_valid16), .out_ready(out_ready16),
      .prod(prod16), .out_mode(out_mode16), .busy(busy16)
   );

   // Reference: true product, minus the cleared low bits of al*bl in approximate mode.
   function automatic logic [31:0] model(input int w, input int t, input logic [15:0] x,
                                         input logic [15:0] y, input logic m);
      longint unsigned hm, ll, p;
      hm = (64'd1 << (w / 2)) - 1;
      ll = (64'(x) & hm) * (64'(y) & hm);
      p  = 64'(x) * 64'(y);
      if (m) p = p - (ll % (64'd1 << t));
      return p[31:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic sb_pop(input string tag, input logic [31:0] got_p, input logic got_m,
                         inout exp_t q[$]);
      exp_t e;
      checks++;
      assert (q.size() > 0) else begin
         failures++;
         $error("FAIL %s_spurious got=output %0d expected=no output", tag, got_p);
      end
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({tag, "_prod"}, got_p, e.p);
         chk({tag, "_mode"}, 32'(got_m), 32'(e.m));
         $display("%s out prod=%0d mode=%0d", tag, got_p, got_m);
      end
   endtask

   // Observe handshakes mid-cycle, then advance one clock edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (in_valid8 && in_ready8) begin
         e.p = model(8, 4, 16'(a8), 16'(b8), mode8);
         e.m = mode8;
         q8.push_back(e);
      end
      if (in_valid16 && in_ready16) begin
         e.p = model(16, 0, a16, b16, mode16);
         e.m = mode16;
         q16.push_back(e);
      end
      if (out_valid8 && out_ready8)   sb_pop("d8", 32'(prod8), out_mode8, q8);
      if (out_valid16 && out_ready16) sb_pop("d16", prod16, out_mode16, q16);
      @(posedge clk);
      #1;
   endtask

   task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic m);
      in_valid8 = 1'b1; a8 = x; b8 = y; mode8 = m;
   endtask

   initial begin
      logic [15:0] held;
      rst_n = 1'b0;
      in_valid8 = 0; a8 = 0; b8 = 0; mode8 = 0; out_ready8 = 1;
      in_valid16 = 0; a16 = 0; b16 = 0; mode16 = 0; out_ready16 = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid8), 0);
      chk("rst_busy", 32'(busy8), 0);
      chk("rst_in_ready", 32'(in_ready8), 1);
      chk("rst_prod", 32'(prod8), 0);
      chk("rst_out_mode", 32'(out_mode8), 0);
      rst_n = 1'b1;
      chk("post_rst_in_ready", 32'(in_ready8), 1);

      // Latency: beat offered in one cycle shows up after the third following edge
      drive8(8'd255, 8'd255, 1'b0);
      tick();
      in_valid8 = 0;
      chk("lat_e1_valid", 32'(out_valid8), 0);
      tick();
      chk("lat_e2_valid", 32'(out_valid8), 0);
      tick();
      chk("lat_e3_valid", 32'(out_valid8), 1);
      chk("exact_255", 32'(prod8), 65025);
      chk("exact_mode", 32'(out_mode8), 0);
      tick();

      drive8(8'd255, 8'd255, 1'b1);
      tick();
      in_valid8 = 0;
      tick();
      tick();
      chk("approx_255", 32'(prod8), 65024);
      chk("approx_mode", 32'(out_mode8), 1);
      tick();

      // Back-to-back stream with mode switching per beat
      drive8(8'd3, 8'd5, 1'b0);    tick();
      drive8(8'd16, 8'd16, 1'b1);  tick();
      drive8(8'd15, 8'd15, 1'b1);  tick();
      in_valid8 = 0;
      chk("stream0_valid", 32'(out_valid8), 1);
      chk("stream0_prod", 32'(prod8), 15);
      tick();
      chk("stream1_valid", 32'(out_valid8), 1);
      chk("stream1_prod", 32'(prod8), 256);
      tick();
      chk("stream2_valid", 32'(out_valid8), 1);
      chk("stream2_prod", 32'(prod8), 224);
      repeat (3) tick();
      chk("stream_drained", q8.size(), 0);

      // Stall with the pipeline full and another beat waiting
      drive8(8'd200, 8'd7, 1'b0);  tick();
      drive8(8'd99, 8'd99, 1'b1);  tick();
      drive8(8'd17, 8'd250, 1'b0); tick();
      out_ready8 = 0;
      drive8(8'd123, 8'd45, 1'b1);
      tick();
      drive8(8'd77, 8'd66, 1'b0);
      held = prod8;
      for (int i = 0; i < 5; i++) begin
         chk("stall_in_ready", 32'(in_ready8), 0);
         chk("stall_out_valid", 32'(out_valid8), 1);
         chk("stall_prod_hold", 32'(prod8), 32'(held));
         tick();
      end
      out_ready8 = 1;
      tick();
      in_valid8 = 0;
      repeat (6) tick();
      chk("stall_drained", q8.size(), 0);

      // Random traffic on both instances with random backpressure
      for (int i = 0; i < 60; i++) begin
         in_valid8   = ($urandom_range(0, 3) != 0);
         a8          = 8'($urandom);
         b8          = 8'($urandom);
         mode8       = 1'($urandom);
         out_ready8  = ($urandom_range(0, 3) != 0);
         in_valid16  = ($urandom_range(0, 3) != 0);
         a16         = 16'($urandom);
         b16         = 16'($urandom);
         mode16      = 1'($urandom);
         out_ready16 = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid8 = 0; in_valid16 = 0; out_ready8 = 1; out_ready16 = 1;
      repeat (6) tick();
      chk("rand8_drained", q8.size(), 0);
      chk("rand16_drained", q16.size(), 0);

      // Reset with two beats in flight
      drive8(8'd11, 8'd13, 1'b0); tick();
      drive8(8'd21, 8'd23, 1'b1); tick();
      in_valid8 = 0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid8), 0);
      chk("midrst_busy", 32'(busy8), 0);
      chk("midrst_in_ready", 32'(in_ready8), 1);
      q8.delete();
      q16.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("after_rst_no_output", 32'(out_valid8), 0);
         tick();
      end
      drive8(8'd12, 8'd12, 1'b1);
      tick();
      in_valid8 = 0;
      repeat (4) tick();
      chk("final_drained", q8.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
